// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants for the rx/tx pair.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Counter width for a bit-period counter; never narrower than one bit.
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for an idle-high asynchronous line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Reset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling and framing check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                 c_CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam int                 c_IDX_W    = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    logic                 w_rx_s;

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] r_dout;
    logic [DATA_BITS-1:0] w_dout_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_ferr;
    logic                 w_ferr_nxt;
    logic                 r_busy;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end

            // Re-check the line half a bit in; a short low pulse is dropped silently.
            START: begin
                if (r_cnt != c_HALF) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end else if (!w_rx_s) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            DATA: begin
                if (r_cnt != c_LAST) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end else begin
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_cnt_nxt          = '0;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end

            // Leave at mid-stop so a following start edge is not missed.
            STOP: begin
                if (r_cnt != c_LAST) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    if (w_rx_s) begin
                        w_dout_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign data_out   = r_dout;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 4 and 1 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    typedef struct {
        int         ch;
        int         cyc;
        logic       err;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         busy_hi4 = 0;

    logic       rst_n4, rx4, dv4, fe4, busy4;
    logic [7:0] dout4;
    logic       rst_n1, rx1, dv1, fe1, busy1;
    logic [7:0] dout1;

    logic [7:0] ref_d [2];
    ev_t        got_q[$];
    ev_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk        (clk),
        .reset_n    (rst_n4),
        .rx         (rx4),
        .data_out   (dout4),
        .data_valid (dv4),
        .frame_err  (fe4),
        .busy       (busy4)
    );

    uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk        (clk),
        .reset_n    (rst_n1),
        .rx         (rx1),
        .data_out   (dout1),
        .data_valid (dv1),
        .frame_err  (fe1),
        .busy       (busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Output events recorded with the cycle they are visible in.
    always @(negedge clk) begin
        if (dv4 || fe4) begin
            check("excl4", 32'(dv4 & fe4), 32'd0);
            check("busy_at_pulse4", 32'(busy4), 32'd0);
            got_q.push_back('{0, cyc, fe4, dout4});
        end
        if (dv1 || fe1) begin
            check("excl1", 32'(dv1 & fe1), 32'd0);
            check("busy_at_pulse1", 32'(busy1), 32'd0);
            got_q.push_back('{1, cyc, fe1, dout1});
        end
        if (busy4) busy_hi4++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int ch, input logic v);
        if (ch == 0) rx4 = v;
        else         rx1 = v;
    endtask

    // Called at a negedge; returns at the negedge that ends the stop bit.
    // At one clock per bit the start bit is held two cycles, since the receiver
    // confirms start one cycle after detecting it.
    task automatic send(input int ch, input logic [7:0] b, input logic stop);
        int         c;
        int         h;
        int         t0;
        logic [9:0] fr;
        c  = (ch == 1) ? 1 : 4;
        h  = (c - 1) / 2;
        fr = {stop, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            drive(ch, fr[i]);
            idle((i == 0 && c == 1) ? 2 : c);
        end
        drive(ch, 1'b1);
        exp_q.push_back('{ch, t0 + 4 + h + 9 * c, !stop, b});
        if (stop) ref_d[ch] = b;
    endtask

    task automatic drain();
        int n;
        check("event_count", 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("ev_chan", 32'(got_q[i].ch), 32'(exp_q[i].ch));
            check("ev_cycle", 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
            check("ev_kind", 32'(got_q[i].err), 32'(exp_q[i].err));
            if (!exp_q[i].err) check("ev_data", 32'(got_q[i].d), 32'(exp_q[i].d));
        end
        got_q.delete();
        exp_q.delete();
        check("data_out4", 32'(dout4), 32'(ref_d[0]));
        check("data_out1", 32'(dout1), 32'(ref_d[1]));
    endtask

    initial begin
        int         b0;
        logic [7:0] rb;
        logic       rs;
        logic [7:0] v55;

        rx4 = 1'b1; rx1 = 1'b1; rst_n4 = 1'b0; rst_n1 = 1'b0;
        ref_d[0] = 8'h00; ref_d[1] = 8'h00;
        idle(3);
        check("rst_dout", 32'(dout4), 32'h00);
        check("rst_valid", 32'(dv4), 32'd0);
        check("rst_ferr", 32'(fe4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        rst_n4 = 1'b1; rst_n1 = 1'b1;

        // Idle line
        b0 = busy_hi4;
        idle(200);
        check("idle_busy", 32'(busy_hi4 - b0), 32'd0);
        drain();

        // Single good frame
        send(0, 8'hA5, 1'b1);
        idle(20);
        drain();

        // One-cycle glitch: busy for H+1 cycles, nothing reported
        b0 = busy_hi4;
        rx4 = 1'b0;
        idle(1);
        rx4 = 1'b1;
        idle(10);
        check("glitch_busy", 32'(busy_hi4 - b0), 32'd2);
        drain();

        // Framing error keeps the previous byte
        send(0, 8'h3C, 1'b0);
        idle(20);
        drain();

        // Back-to-back frames
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        idle(20);
        drain();

        // Reset during bit 3 of 8'h55
        v55 = 8'h55;
        rx4 = 1'b0;
        idle(4);
        for (int i = 0; i < 3; i++) begin
            rx4 = v55[i];
            idle(4);
        end
        rx4 = v55[3];
        idle(2);
        rst_n4 = 1'b0;
        idle(1);
        rst_n4 = 1'b1;
        rx4 = 1'b1;
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_dout", 32'(dout4), 32'h00);
        check("midrst_valid", 32'(dv4), 32'd0);
        ref_d[0] = 8'h00;
        idle(20);
        drain();
        send(0, 8'h81, 1'b1);
        idle(20);
        drain();

        // Random frames; a bad stop is followed by enough idle to re-arm cleanly
        for (int k = 0; k < 16; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(0, rb, rs);
            if (!rs) idle(6);
            else     idle($urandom_range(0, 3));
        end
        idle(20);
        drain();

        // One clock per bit
        send(1, 8'hC3, 1'b1);
        idle(20);
        drain();
        for (int k = 0; k < 6; k++) begin
            send(1, 8'($urandom), 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(20);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
